step_motor_exec: RTL

//  Executor end of the motor command interface: accepts start/stop/modify-remain

---
 rtl/step_motor_pkg.sv | 28 ++
 rtl/step_motor_exec_sync2.sv | 22 ++
 rtl/step_motor_exec.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/step_motor_pkg.sv
// Shared types and helpers for the stepper motor executor.
package step_motor_pkg;

  // Executor FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    PULSE_HI = 2'd2,
    PULSE_LO = 2'd3
  } motor_state_t;

  // Shortest step period the driver can be fed (one high, one low cycle).
  localparam int MIN_PERIOD = 2;

  // Widest count the helpers handle; callers sign-extend into this width.
  localparam int MAX_W = 64;

  // Magnitude of a two's-complement value (most negative value wraps to itself).
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? (~v) + MAX_W'(1) : v;
  endfunction

  // Sign bit of a two's-complement value: 1 means negative.
  function automatic logic sign_w(input logic [MAX_W-1:0] v);
    return v[MAX_W-1];
  endfunction

endpackage

// File: rtl/step_motor_exec_sync2.sv
// Two-flop synchronizer for one asynchronous sensor input.
module sig_sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the raw input twice before anything downstream uses it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_motor_exec.sv
// Executor end of the motor command interface: turns start/stop/modify-remain
// commands into step/dir pulses for one stepper driver and tracks position.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no motion; waits for a start command
//   SETUP    | dir pin settled, waiting C_DIR_SETUP cycles before first step
//   PULSE_HI | step pin high for floor(period/2) cycles
//   PULSE_LO | step pin low for the rest of the period; decide next step
module step_motor_exec
  import step_motor_pkg::*;
#(
  parameter int unsigned C_STEP_NUMBER_WIDTH = 32,
  parameter int unsigned C_SPEED_DATA_WIDTH  = 32,
  parameter int unsigned C_DIR_SETUP         = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           s_sel,
  input  logic                           s_start,
  input  logic                           s_stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  s_speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s_step,
  input  logic                           s_abs,
  input  logic                           s_mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s_new_remain,
  output logic                           s_state,
  output logic                           s_rt_dir,
  output logic [C_STEP_NUMBER_WIDTH-1:0] s_position,
  output logic                           s_ntsign,
  output logic                           s_zpsign,
  output logic                           s_ptsign,
  output logic                           s_dep_state,
  output logic                           o_step,
  output logic                           o_dir,
  input  logic                           i_ntsign,
  input  logic                           i_zpsign,
  input  logic                           i_ptsign
);

  localparam int unsigned STP = C_STEP_NUMBER_WIDTH;
  localparam int unsigned SPD = C_SPEED_DATA_WIDTH;

  motor_state_t   state_q, state_nxt;
  logic [SPD-1:0] period_q, cnt_q, cnt_nxt, hi_len, lo_len, speed_clamped;
  logic [STP-1:0] pos_q, remain_q, delta, start_remain, new_remain_abs, remain_eff;
  logic           dir_q, run_q, stop_pend_q, step_q, dep_q;
  logic           nt_s, zp_s, pt_s;
  logic           start_ok, start_dir, start_null, stop_req, mod_ok;
  logic           limit_hit, stop_eff, cnt_zero, end_run, enter_hi;

  sig_sync2 u_sync_nt (.clk(clk), .resetn(resetn), .d(i_ntsign), .q(nt_s));
  sig_sync2 u_sync_zp (.clk(clk), .resetn(resetn), .d(i_zpsign), .q(zp_s));
  sig_sync2 u_sync_pt (.clk(clk), .resetn(resetn), .d(i_ptsign), .q(pt_s));

  // Command decode: start only from a quiet IDLE, stop/modify only while moving.
  always_comb begin
    delta          = s_abs ? (s_step - pos_q) : s_step;
    start_dir      = sign_w(MAX_W'(signed'(delta)));
    start_remain   = STP'(abs_w(MAX_W'(signed'(delta))));
    new_remain_abs = STP'(abs_w(MAX_W'(signed'(s_new_remain))));
    speed_clamped  = (s_speed < SPD'(MIN_PERIOD)) ? SPD'(MIN_PERIOD) : s_speed;
    start_ok       = s_sel & s_start & (state_q == IDLE) & ~run_q;
    start_null     = (delta == '0) | (start_dir ? nt_s : pt_s);
    stop_req       = s_sel & s_stop & (state_q != IDLE);
    mod_ok         = s_sel & s_mod_remain & ~s_stop & (state_q != IDLE)
                     & (s_new_remain[STP-1] == dir_q);
    // A stop or remain rewrite arriving on the deciding cycle still counts.
    remain_eff     = mod_ok ? new_remain_abs : remain_q;
    stop_eff       = stop_pend_q | stop_req;
    limit_hit      = dir_q ? nt_s : pt_s;
    end_run        = (remain_eff == '0) | stop_eff | limit_hit;
    hi_len         = period_q >> 1;
    lo_len         = period_q - hi_len;
    cnt_zero       = (cnt_q == '0);
  end

  // Next-state and phase-counter logic; the counter runs down to zero per phase.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_zero ? '0 : cnt_q - SPD'(1);
    enter_hi  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok && !start_null) begin
          state_nxt = SETUP;
          cnt_nxt   = SPD'(C_DIR_SETUP - 1);
        end
      end
      SETUP, PULSE_LO: begin
        if (cnt_zero) begin
          if (end_run) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = PULSE_HI;
            cnt_nxt   = hi_len - SPD'(1);
            enter_hi  = 1'b1;
          end
        end
      end
      PULSE_HI: begin
        if (cnt_zero) begin
          state_nxt = PULSE_LO;
          cnt_nxt   = lo_len - SPD'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, phase counter and registered step pin.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      step_q  <= (state_nxt == PULSE_HI);
    end
  end

  // Motion parameters latched at start; remain and pending-stop track the run.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_q    <= SPD'(MIN_PERIOD);
      dir_q       <= 1'b0;
      remain_q    <= '0;
      run_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else if (start_ok) begin
      period_q    <= speed_clamped;
      dir_q       <= start_dir;
      remain_q    <= start_remain;
      run_q       <= 1'b1;
      stop_pend_q <= 1'b0;
    end else begin
      if (state_nxt == IDLE) begin
        run_q       <= 1'b0;
        stop_pend_q <= 1'b0;
      end else if (stop_req) begin
        stop_pend_q <= 1'b1;
      end
      if (mod_ok) begin
        remain_q <= new_remain_abs;
      end else if (enter_hi) begin
        remain_q <= remain_q - STP'(1);
      end
    end
  end

  // Position moves by one on every step rising edge, wrapping in two's complement.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pos_q <= '0;
    end else if (enter_hi) begin
      pos_q <= dir_q ? pos_q - STP'(1) : pos_q + STP'(1);
    end
  end

  // Running status delayed one cycle for dependent axes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dep_q <= 1'b0;
    end else begin
      dep_q <= run_q;
    end
  end

  assign s_state     = run_q;
  assign s_rt_dir    = dir_q;
  assign o_dir       = dir_q;
  assign o_step      = step_q;
  assign s_position  = pos_q;
  assign s_dep_state = dep_q;
  assign s_ntsign    = nt_s;
  assign s_zpsign    = zp_s;
  assign s_ptsign    = pt_s;

endmodule
